wb_port_arbiter: RTL and testbench

- Shares the single register-file write port of the riscv32i core between NUM_REQ write-back requesters, such as the ALU result path and the load unit.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The winning write is registered onto the register-file write port one cycle after acceptance. Writes to x0 are dropped.
- A saturating counter records contention cycles for performance debug.

---
 rtl/wb_port_arbiter.sv | 83 ++++++++
 tb/tb_wb_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// write-back requesters; the winning write is registered one cycle after acceptance.
module wb_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [XLEN-1:0]           wr_data,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: requester i transfers on a rising edge where
  // req_valid[i] && req_ready[i]; req_ready is a one-hot combinational grant,
  // held at zero during reset so nothing is accepted while rst=1.

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              multi_valid;
  int                idx;

  // Scan from ptr upward with an explicit wrap so non-power-of-two
  // NUM_REQ never produces an out-of-range index.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    idx       = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any        = 1'b1;
          gnt_idx        = PTR_W'(idx);
          req_ready[idx] = 1'b1;
          sel_rd         = req_rd[idx*ADDR_W +: ADDR_W];
          sel_data       = req_data[idx*XLEN +: XLEN];
        end
      end
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_any) begin
        wr_en   <= (sel_rd != '0);
        wr_addr <= sel_rd;
        wr_data <= sel_data;
        ptr     <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end else begin
        wr_en <= 1'b0;
      end
      if (multi_valid && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized
// protocol-compliant run compared against a grant-order reference model.
module tb_wb_port_arbiter;

  localparam int N    = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;
  localparam int CW_S = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_rd;
  logic [N*XLEN-1:0] req_data;
  logic [N-1:0]      req_ready, s_req_ready;
  logic              wr_en, s_wr_en;
  logic [AW-1:0]     wr_addr, s_wr_addr;
  logic [XLEN-1:0]   wr_data, s_wr_data;
  logic [CW-1:0]     conflict_cnt;
  logic [CW_S-1:0]   s_conflict_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .conflict_cnt(conflict_cnt));

  wb_port_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .ADDR_W(AW), .CNT_W(CW_S)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(s_req_ready), .wr_en(s_wr_en),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .conflict_cnt(s_conflict_cnt));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int              m_ptr = 0;
  logic            m_en = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  int              m_cnt = 0;
  int              m_cnt_s = 0;
  int              m_last_g = -1;

  logic [AW+XLEN-1:0] exp_q[$];

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and the model; returns at posedge+1.
  task automatic tick();
    int g, pc;
    logic [AW-1:0] rd;
    logic [XLEN-1:0] d;
    g  = model_grant();
    pc = $countones(req_valid);
    rd = (g >= 0) ? req_rd[g*AW +: AW] : '0;
    d  = (g >= 0) ? req_data[g*XLEN +: XLEN] : '0;
    @(posedge clk);
    if (rst) begin
      m_en = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_cnt_s = 0; m_ptr = 0;
    end else begin
      if (g >= 0) begin
        m_en = (rd != '0); m_addr = rd; m_data = d; m_ptr = (g + 1) % N;
      end else begin
        m_en = 1'b0;
      end
      if (pc >= 2) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_cnt_s < (1 << CW_S) - 1) m_cnt_s++;
      end
    end
    m_last_g = g;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11;
    req_rd = {5'd7, 5'd3}; req_data = {32'hAAAA_5555, 32'h1111_2222};
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=00", c, req_ready);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || conflict_cnt !== '0 ||
          s_conflict_cnt !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got en=%b addr=%0d data=%h cnt=%0d scnt=%0d exp all 0",
                 c, wr_en, wr_addr, wr_data, conflict_cnt, s_conflict_cnt);
      end
    end
  endtask

  task automatic test_single();
    rst = 1'b0; req_valid = 2'b01;
    req_rd = {5'd9, 5'd5}; req_data = {32'h0, 32'hDEAD_BEEF};
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef",
                        wr_en, wr_addr, wr_data);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || conflict_cnt !== '0) begin
      n_err++; $display("FAIL single_idle got en=%b addr=%0d cnt=%0d exp en=0 addr=5 cnt=0",
                        wr_en, wr_addr, conflict_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_r;
    do_reset();
    req_valid = 2'b11;
    req_rd = {5'd2, 5'd1}; req_data = {32'h2222_0002, 32'h1111_0001};
    for (int c = 0; c < 6; c++) begin
      exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_cmp++;
      if (req_ready !== exp_r) begin
        n_err++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_r);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== ((c % 2 == 0) ? 5'd1 : 5'd2)) begin
        n_err++; $display("FAIL rr_write cyc=%0d got en=%b addr=%0d", c, wr_en, wr_addr);
      end
    end
    n_cmp++;
    if (conflict_cnt !== 16'd6) begin
      n_err++; $display("FAIL rr_conflict got=%0d exp=6", conflict_cnt);
    end
  endtask

  task automatic test_x0();
    req_valid = 2'b10;
    req_rd = {5'd0, 5'd12}; req_data = {32'h0000_1234, 32'hCAFE_F00D};
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL x0_ready got=%b exp=10", req_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_err++; $display("FAIL x0_dropped got en=%b exp=0", wr_en);
    end
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL x0_ptr_advance got=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL x0_next_write got en=%b addr=%0d data=%h exp 1/12/cafef00d",
                        wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b11;
    req_rd = {5'd20, 5'd10}; req_data = {32'hB0B0_0020, 32'hA0A0_0010};
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL rstmid_ready got=%b exp=00", req_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || conflict_cnt !== '0 || wr_addr !== '0) begin
      n_err++; $display("FAIL rstmid_cancel got en=%b cnt=%0d addr=%0d exp 0/0/0",
                        wr_en, conflict_cnt, wr_addr);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rstmid_first_grant got=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
  endtask

  task automatic test_saturation();
    int exp_s;
    do_reset();
    req_valid = 2'b11;
    req_rd = {5'd4, 5'd3}; req_data = {32'h4, 32'h3};
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_s = (c > 15) ? 15 : c;
      n_cmp++;
      if (int'(s_conflict_cnt) != exp_s) begin
        n_err++; $display("FAIL sat_count cyc=%0d got=%0d exp=%0d", c, s_conflict_cnt, exp_s);
      end
    end
    n_cmp++;
    if (conflict_cnt !== 16'd20) begin
      n_err++; $display("FAIL sat_wide_count got=%0d exp=20", conflict_cnt);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    logic [AW+XLEN-1:0] got, exp;
    int g;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      // Requesters hold until transfer, then may drop or present a new write.
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_last_g == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_rd[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          req_data[i*XLEN +: XLEN] = $urandom;
        end
      end
      #1;
      exp_r = model_ready();
      n_cmp++;
      if (req_ready !== exp_r) begin
        n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_r);
      end
      g = model_grant();
      if (g >= 0 && req_rd[g*AW +: AW] != '0)
        exp_q.push_back({req_rd[g*AW +: AW], req_data[g*XLEN +: XLEN]});
      tick();
      n_cmp++;
      if (wr_en !== m_en || conflict_cnt !== CW'(m_cnt) || s_conflict_cnt !== CW_S'(m_cnt_s)) begin
        n_err++; $display("FAIL rand_state cyc=%0d got en=%b cnt=%0d scnt=%0d exp en=%b cnt=%0d scnt=%0d",
                          c, wr_en, conflict_cnt, s_conflict_cnt, m_en, m_cnt, m_cnt_s);
      end
      if (wr_en === 1'b1) begin
        got = {wr_addr, wr_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_write cyc=%0d got=%h exp=none", c, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++; $display("FAIL rand_write cyc=%0d got=%h exp=%h", c, got, exp);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_leftover got=%0d pending exp=0", exp_q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
